// File: rtl/switch_debounce2.sv
// Two-channel switch conditioner: 2-flop synchroniser, debounce, edge pulses
// and a press-to-toggle latch per channel.
module switch_debounce2 #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a_raw,
  input  logic sw_b_raw,
  input  logic toggle_mode,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic busy
);

  localparam int unsigned NCH = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  state_t           state [NCH];
  logic [CNT_W-1:0] cnt   [NCH];
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   tog;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   fall;

  assign raw = {sw_b_raw, sw_a_raw};

  // Channels share one process but never read each other's state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      tog    <= '0;
      rise   <= '0;
      fall   <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= ST_STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < NCH; i++) begin
        case (state[i])
          ST_STABLE: begin
            if (s2[i] != stable[i]) begin
              if (DEBOUNCE_CYCLES == 32'd1) begin
                // Single-cycle debounce: accept the new level immediately.
                stable[i] <= s2[i];
                rise[i]   <= s2[i];
                fall[i]   <= ~s2[i];
                if (s2[i]) tog[i] <= ~tog[i];
              end else begin
                state[i] <= ST_COUNTING;
                cnt[i]   <= CNT_W'(1);
              end
            end
          end
          ST_COUNTING: begin
            if (s2[i] == stable[i]) begin
              state[i] <= ST_STABLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == LAST_CNT) begin
              state[i]  <= ST_STABLE;
              cnt[i]    <= '0;
              stable[i] <= s2[i];
              rise[i]   <= s2[i];
              fall[i]   <= ~s2[i];
              if (s2[i]) tog[i] <= ~tog[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= ST_STABLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Mode select is a plain mux so a mode change shows up without a clock edge.
  assign a      = toggle_mode ? tog[0] : stable[0];
  assign b      = toggle_mode ? tog[1] : stable[1];
  assign a_rise = rise[0];
  assign a_fall = fall[0];
  assign b_rise = rise[1];
  assign b_fall = fall[1];
  assign busy   = (cnt[0] != '0) || (cnt[1] != '0);

endmodule

// File: tb/tb_switch_debounce2.sv
// Directed bench for switch_debounce2 with DEBOUNCE_CYCLES = 4.
module tb_switch_debounce2;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_a_raw;
  logic sw_b_raw;
  logic toggle_mode;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic busy;

  int checks = 0;
  int errors = 0;
  int n_a_rise = 0;
  int n_a_fall = 0;
  int n_b_rise = 0;
  int n_b_fall = 0;
  int snap_ar, snap_af, snap_br, snap_bf;

  switch_debounce2 #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_a_raw   (sw_a_raw),
    .sw_b_raw   (sw_b_raw),
    .toggle_mode(toggle_mode),
    .a          (a),
    .b          (b),
    .a_rise     (a_rise),
    .a_fall     (a_fall),
    .b_rise     (b_rise),
    .b_fall     (b_fall),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (a_rise) n_a_rise++;
    if (a_fall) n_a_fall++;
    if (b_rise) n_b_rise++;
    if (b_fall) n_b_fall++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] outs();
    return {a, b, a_rise, a_fall, b_rise, b_fall, busy};
  endfunction

  initial begin
    rst_n       = 1'b0;
    sw_a_raw    = 1'b1;
    sw_b_raw    = 1'b1;
    toggle_mode = 1'b0;

    // 1. Reset with raw inputs high, then release
    #1;
    check("reset_async", 32'(outs()), 32'h0);
    step(3);
    check("reset_hold", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    step(3);
    check("rel_busy_e3", 32'({a, b, busy}), 32'b001);
    step(2);
    check("rel_e5_low", 32'({a, b, a_rise, b_rise}), 32'b0000);
    step(1);
    check("rel_e6_rise", 32'(outs()), 32'b1110100);
    step(1);
    check("rel_e7_pulse_end", 32'(outs()), 32'b1100000);

    // 2. Release A, then clean press on A
    sw_a_raw = 1'b0;
    step(5);
    check("a_release_k4", 32'({a, a_fall}), 32'b10);
    step(1);
    check("a_release_k5", 32'({a, a_rise, a_fall}), 32'b001);
    step(1);
    check("a_release_pulse_end", 32'({a, a_fall}), 32'b00);
    snap_af = n_a_fall;
    snap_ar = n_a_rise;
    sw_a_raw = 1'b1;
    step(5);
    check("press_k4", 32'({a, busy}), 32'b01);
    step(1);
    check("press_k5", 32'(outs()), 32'b1110000);
    step(1);
    check("press_pulse_end", 32'({a, a_rise, b}), 32'b101);
    check("press_rise_cnt", 32'(n_a_rise - snap_ar), 32'd1);
    check("press_no_fall", 32'(n_a_fall - snap_af), 32'd0);

    // 3. Bounce rejection from stable 0
    sw_a_raw = 1'b0;
    step(10);
    check("bounce_pre_a", 32'(a), 32'd0);
    snap_ar = n_a_rise;
    snap_af = n_a_fall;
    sw_a_raw = 1'b1; step(2);
    sw_a_raw = 1'b0; step(1);
    check("bounce_busy", 32'(busy), 32'd1);
    step(1);
    sw_a_raw = 1'b1; step(2);
    sw_a_raw = 1'b0; step(2);
    step(6);
    check("bounce_settled", 32'({a, busy}), 32'b00);
    check("bounce_no_pulses", 32'((n_a_rise - snap_ar) + (n_a_fall - snap_af)), 32'd0);

    // 4. Toggle mode on B from a fresh reset
    sw_b_raw = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    toggle_mode = 1'b1;
    #1;
    check("tog_start", 32'(b), 32'd0);
    snap_br = n_b_rise;
    snap_bf = n_b_fall;
    for (int p = 0; p < 3; p++) begin
      sw_b_raw = 1'b1;
      step(8);
      check("tog_press", 32'(b), 32'((p % 2) == 0));
      sw_b_raw = 1'b0;
      step(8);
      check("tog_release", 32'(b), 32'((p % 2) == 0));
    end
    check("tog_rise_cnt", 32'(n_b_rise - snap_br), 32'd3);
    check("tog_fall_cnt", 32'(n_b_fall - snap_bf), 32'd3);
    toggle_mode = 1'b0;
    #1;
    check("tog_mode_off", 32'(b), 32'd0);

    // 5. Simultaneous press on both channels
    step(1);
    sw_a_raw = 1'b1;
    sw_b_raw = 1'b1;
    step(5);
    check("both_k4", 32'({a, b, busy}), 32'b001);
    step(1);
    check("both_k5", 32'(outs()), 32'b1110100);
    step(1);
    check("both_pulse_end", 32'(outs()), 32'b1100000);

    // 6. Reset in the middle of an A count
    sw_a_raw = 1'b0;
    sw_b_raw = 1'b0;
    step(10);
    check("mid_pre", 32'({a, b}), 32'b00);
    sw_a_raw = 1'b1;
    step(4);
    check("mid_counting", 32'({a, busy}), 32'b01);
    snap_ar = n_a_rise;
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", 32'(outs()), 32'h0);
    step(3);
    check("mid_no_rise", 32'(n_a_rise - snap_ar), 32'd0);
    rst_n = 1'b1;
    step(5);
    check("mid_rel_e5", 32'({a, a_rise}), 32'b00);
    step(1);
    check("mid_rel_e6", 32'({a, a_rise, b}), 32'b110);
    step(1);
    check("mid_rel_e7", 32'({a, a_rise}), 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
